wb_stage: RTL and testbench

- Writeback stage directly downstream of the memory stage.
- Consumes the memory-stage results, the forwarded execute value and the RAM read word.
- Performs load byte/halfword extraction with sign/zero extension and drives the register-file write port.
- Publishes a WB bypass pair for the execute stage's forwarding mux, and keeps retire and misalignment counters for the debug/trace block.

---
 rtl/wb_stage.sv | 200 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage, directly downstream of the memory stage.
//
// Takes the memory-stage results, extracts and extends load data from the RAM
// read word, drives the register-file write port, publishes a WB bypass pair
// for the execute-stage forwarding mux and keeps retire / misaligned-load
// counters for the debug/trace block. Every output is registered, so there is
// no combinational path from any input to any output.
//
// Handshake: an instruction is accepted on a posedge where in_valid is high and
// stall is low. While stall is high the upstream stage holds its outputs, so
// the same instruction is presented again and is accepted exactly once, on the
// first unstalled edge. There is no ready output; stall is the back-pressure.
//
// Encodings shared with the decode / memory stages:
//   insn_type     : R=0, I=1, L=2, S=3, B=4, J=5, U=6
//   load_sub_type : L_B=0, L_H=1, L_W=2, L_BU=3, L_HU=4 (anything else unknown)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall, in_valid acceptance control (see above)
//   insn_type       instruction class
//   load_sub_type   load width / signedness
//   addr_lo         byte offset of the load address
//   wb_reg, wb_val  destination register and execute result
//   use_mem_output  select extracted RAM data instead of wb_val
//   ram_r_data      RAM read word, valid alongside the memory-stage outputs
//   rf_w_en/addr/data  register-file write port
//   bp_wb_reg/val   bypass pair, reg 0 means no bypass
//   retired_cnt     accepted-instruction count (wraps)
//   misalign_err    sticky misaligned-load flag
//   misalign_cnt    saturating misaligned-load count
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MA_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                in_valid,
  input  logic [3:0]          insn_type,
  input  logic [3:0]          load_sub_type,
  input  logic [1:0]          addr_lo,
  input  logic [REG_AW-1:0]   wb_reg,
  input  logic [XLEN-1:0]     wb_val,
  input  logic                use_mem_output,
  input  logic [XLEN-1:0]     ram_r_data,
  output logic                rf_w_en,
  output logic [REG_AW-1:0]   rf_w_addr,
  output logic [XLEN-1:0]     rf_w_data,
  output logic [REG_AW-1:0]   bp_wb_reg,
  output logic [XLEN-1:0]     bp_wb_val,
  output logic [31:0]         retired_cnt,
  output logic                misalign_err,
  output logic [MA_CNT_W-1:0] misalign_cnt
);

  localparam logic [3:0] TYPE_L = 4'd2;
  localparam logic [3:0] TYPE_S = 4'd3;
  localparam logic [3:0] TYPE_B = 4'd4;

  localparam logic [3:0] LD_B  = 4'd0;
  localparam logic [3:0] LD_H  = 4'd1;
  localparam logic [3:0] LD_W  = 4'd2;
  localparam logic [3:0] LD_BU = 4'd3;
  localparam logic [3:0] LD_HU = 4'd4;

  localparam logic [MA_CNT_W-1:0] MA_ONE = {{(MA_CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic                rf_w_en_q,      rf_w_en_d;
  logic [REG_AW-1:0]   rf_w_addr_q,    rf_w_addr_d;
  logic [XLEN-1:0]     rf_w_data_q,    rf_w_data_d;
  logic [REG_AW-1:0]   bp_wb_reg_q,    bp_wb_reg_d;
  logic [XLEN-1:0]     bp_wb_val_q,    bp_wb_val_d;
  logic [31:0]         retired_cnt_q,  retired_cnt_d;
  logic                misalign_err_q, misalign_err_d;
  logic [MA_CNT_W-1:0] misalign_cnt_q, misalign_cnt_d;

  // ---------------------------------------------------------------------------
  // Load extraction
  // ---------------------------------------------------------------------------
  logic [15:0]     half_sel;
  logic [7:0]      byte_sel;
  logic [XLEN-1:0] ld_data;
  logic            ld_known;

  // Halfword lane picked by addr_lo[1]; odd offsets are caught as misaligned.
  assign half_sel = addr_lo[1] ? ram_r_data[31:16] : ram_r_data[15:0];
  assign byte_sel = ram_r_data[{addr_lo, 3'b000} +: 8];

  always_comb begin
    ld_data  = '0;
    ld_known = 1'b1;
    case (load_sub_type)
      LD_W:    ld_data = ram_r_data;
      LD_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
      LD_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      default: ld_known = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accept, misalignment and write qualification
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            is_load;
  logic            misaligned;
  logic            no_dest;
  logic            mem_bad;
  logic            wr_en;
  logic [XLEN-1:0] wr_data;

  assign accept  = in_valid & ~stall;
  assign is_load = (insn_type == TYPE_L);

  assign misaligned = is_load &
                      ((load_sub_type == LD_W && addr_lo != 2'b00) ||
                       ((load_sub_type == LD_H || load_sub_type == LD_HU) && addr_lo[0]));

  // Stores and branches carry a wb_reg field that must never be written.
  assign no_dest = (insn_type == TYPE_S) || (insn_type == TYPE_B) || (wb_reg == '0);

  // A RAM-sourced write with an unrecognised sub-type is suppressed (data 0).
  assign mem_bad = use_mem_output & ~ld_known;

  assign wr_data = use_mem_output ? ld_data : wb_val;
  assign wr_en   = accept & ~no_dest & ~misaligned & ~mem_bad;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_w_en_d      = wr_en;
    rf_w_addr_d    = rf_w_addr_q;
    rf_w_data_d    = rf_w_data_q;
    bp_wb_reg_d    = '0;
    bp_wb_val_d    = '0;
    retired_cnt_d  = retired_cnt_q;
    misalign_err_d = misalign_err_q;
    misalign_cnt_d = misalign_cnt_q;

    if (accept) begin
      // The write port tracks the last accepted instruction; consumers gate
      // on rf_w_en, and the value holds across stalls and bubbles.
      rf_w_addr_d   = wb_reg;
      rf_w_data_d   = wr_data;
      retired_cnt_d = retired_cnt_q + 32'd1;
      if (misaligned) begin
        misalign_err_d = 1'b1;
        if (misalign_cnt_q != '1) begin
          misalign_cnt_d = misalign_cnt_q + MA_ONE;
        end
      end
    end

    if (wr_en) begin
      bp_wb_reg_d = wb_reg;
      bp_wb_val_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_w_en_q      <= 1'b0;
      rf_w_addr_q    <= '0;
      rf_w_data_q    <= '0;
      bp_wb_reg_q    <= '0;
      bp_wb_val_q    <= '0;
      retired_cnt_q  <= '0;
      misalign_err_q <= 1'b0;
      misalign_cnt_q <= '0;
    end else begin
      rf_w_en_q      <= rf_w_en_d;
      rf_w_addr_q    <= rf_w_addr_d;
      rf_w_data_q    <= rf_w_data_d;
      bp_wb_reg_q    <= bp_wb_reg_d;
      bp_wb_val_q    <= bp_wb_val_d;
      retired_cnt_q  <= retired_cnt_d;
      misalign_err_q <= misalign_err_d;
      misalign_cnt_q <= misalign_cnt_d;
    end
  end

  assign rf_w_en      = rf_w_en_q;
  assign rf_w_addr    = rf_w_addr_q;
  assign rf_w_data    = rf_w_data_q;
  assign bp_wb_reg    = bp_wb_reg_q;
  assign bp_wb_val    = bp_wb_val_q;
  assign retired_cnt  = retired_cnt_q;
  assign misalign_err = misalign_err_q;
  assign misalign_cnt = misalign_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// Directed scenario tasks plus a randomized run checked against a behavioural
// model of the writeback rules.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int MA_CNT_W = 8;
  localparam int MA_MAX   = (1 << MA_CNT_W) - 1;

  localparam logic [3:0] T_R = 4'd0, T_I = 4'd1, T_L = 4'd2, T_S = 4'd3,
                         T_B = 4'd4, T_J = 4'd5, T_U = 4'd6;
  localparam logic [3:0] L_B = 4'd0, L_H = 4'd1, L_W = 4'd2, L_BU = 4'd3,
                         L_HU = 4'd4, L_BAD = 4'd9;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, stall, in_valid, use_mem_output;
  logic [3:0]          insn_type, load_sub_type;
  logic [1:0]          addr_lo;
  logic [REG_AW-1:0]   wb_reg;
  logic [XLEN-1:0]     wb_val, ram_r_data;
  logic                rf_w_en, misalign_err;
  logic [REG_AW-1:0]   rf_w_addr, bp_wb_reg;
  logic [XLEN-1:0]     rf_w_data, bp_wb_val;
  logic [31:0]         retired_cnt;
  logic [MA_CNT_W-1:0] misalign_cnt;

  wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .MA_CNT_W(MA_CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
    .insn_type(insn_type), .load_sub_type(load_sub_type), .addr_lo(addr_lo),
    .wb_reg(wb_reg), .wb_val(wb_val), .use_mem_output(use_mem_output),
    .ram_r_data(ram_r_data), .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr),
    .rf_w_data(rf_w_data), .bp_wb_reg(bp_wb_reg), .bp_wb_val(bp_wb_val),
    .retired_cnt(retired_cnt), .misalign_err(misalign_err),
    .misalign_cnt(misalign_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid;
    logic        stall;
    logic [3:0]  typ;
    logic [3:0]  sub;
    logic [1:0]  addr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        use_mem;
    logic [31:0] ram;
  } ins_t;

  // ---------------------------------------------------------------------------
  // Reference model: architectural effect of one edge
  // ---------------------------------------------------------------------------
  logic        m_en;
  logic [4:0]  m_addr, m_bp_reg;
  logic [31:0] m_data, m_bp_val, m_ret;
  logic        m_err;
  int          m_cnt;
  logic [REG_AW+XLEN-1:0] exp_q[$];

  function automatic logic [31:0] extract(input logic [3:0] sub, input logic [1:0] a,
                                          input logic [31:0] ram, output logic known);
    logic [31:0] lane;
    known = 1'b1;
    lane  = 32'h0;
    if (sub == L_W) begin
      lane = ram;
    end else if (sub == L_H || sub == L_HU) begin
      lane = (ram >> (16 * a[1])) & 32'hFFFF;
      if (sub == L_H && lane >= 32'h8000) lane = lane + 32'hFFFF0000;
    end else if (sub == L_B || sub == L_BU) begin
      lane = (ram >> (8 * a)) & 32'hFF;
      if (sub == L_B && lane >= 32'h80) lane = lane + 32'hFFFFFF00;
    end else begin
      known = 1'b0;
    end
    return lane;
  endfunction

  task automatic model_reset();
    m_en = 0; m_addr = 0; m_data = 0; m_bp_reg = 0; m_bp_val = 0;
    m_ret = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input ins_t t);
    logic known, mis;
    logic [31:0] ld, data;
    m_en = 0; m_bp_reg = 0; m_bp_val = 0;
    if (t.valid && !t.stall) begin
      ld   = extract(t.sub, t.addr, t.ram, known);
      data = t.use_mem ? ld : t.val;
      mis  = (t.typ == T_L) && ((t.sub == L_W && t.addr % 4 != 0) ||
             ((t.sub == L_H || t.sub == L_HU) && t.addr % 2 != 0));
      m_ret  = m_ret + 1;
      m_addr = t.rd;
      m_data = data;
      if (mis) begin
        m_err = 1;
        if (m_cnt < MA_MAX) m_cnt = m_cnt + 1;
      end
      if (t.typ != T_S && t.typ != T_B && t.rd != 0 && !mis && !(t.use_mem && !known)) begin
        m_en = 1; m_bp_reg = t.rd; m_bp_val = data;
        exp_q.push_back({t.rd, data});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  function automatic ins_t mk(input logic [3:0] typ, input logic [3:0] sub,
                              input logic [1:0] a, input logic [4:0] rd,
                              input logic [31:0] val, input logic use_mem,
                              input logic [31:0] ram);
    ins_t t;
    t.valid = 1; t.stall = 0; t.typ = typ; t.sub = sub; t.addr = a;
    t.rd = rd; t.val = val; t.use_mem = use_mem; t.ram = ram;
    return t;
  endfunction

  task automatic apply(input ins_t t, input logic r);
    rst = r; in_valid = t.valid; stall = t.stall; insn_type = t.typ;
    load_sub_type = t.sub; addr_lo = t.addr; wb_reg = t.rd; wb_val = t.val;
    use_mem_output = t.use_mem; ram_r_data = t.ram;
    if (r) model_reset(); else model_step(t);
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t idle();
    ins_t t;
    t = mk(T_R, L_W, 2'd0, 5'd0, 32'h0, 1'b0, 32'h0);
    t.valid = 0;
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    ins_t t;
    t = mk(T_R, L_W, 0, 5'd5, 32'hDEAD, 0, 0);
    apply(t, 1'b1);
    apply(t, 1'b1);
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%0h exp=0", rf_w_en); end
    n_checks++; if (rf_w_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", rf_w_addr); end
    n_checks++; if (rf_w_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%0h exp=0", rf_w_data); end
    n_checks++; if (bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL reset_bp_reg got=%0h exp=0", bp_wb_reg); end
    n_checks++; if (bp_wb_val !== 32'd0) begin n_fail++; $display("FAIL reset_bp_val got=%0h exp=0", bp_wb_val); end
    n_checks++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_retired got=%0h exp=0", retired_cnt); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0h exp=0", misalign_err); end
    n_checks++; if (misalign_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0h exp=0", misalign_cnt); end
  endtask

  task automatic test_reset_mid();
    ins_t t;
    apply(idle(), 1'b1);
    apply(mk(T_L, L_W, 2'd2, 5'd6, 0, 1, 32'h11223344), 1'b0);
    t = mk(T_R, L_W, 0, 5'd5, 32'hAAAA, 0, 0);
    apply(t, 1'b0);
    n_checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd5) begin n_fail++; $display("FAIL mid_pre_write got=%0h/%0h exp=1/5", rf_w_en, rf_w_addr); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mid_pre_err got=%0h exp=1", misalign_err); end
    apply(t, 1'b1);
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en got=%0h exp=0", rf_w_en); end
    n_checks++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_retired got=%0h exp=0", retired_cnt); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got=%0h exp=0", misalign_err); end
    n_checks++; if (bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL mid_rst_bp_reg got=%0h exp=0", bp_wb_reg); end
  endtask

  task automatic test_load_extract();
    logic [3:0]  subs[8] = '{L_B, L_B, L_BU, L_H, L_HU, L_W, L_B, L_H};
    logic [1:0]  adrs[8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0};
    logic [31:0] exps[8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                             32'h000080FF, 32'h80FF7F01, 32'hFFFFFF80, 32'h00007F01};
    apply(idle(), 1'b1);
    for (int i = 0; i < 8; i++) begin
      apply(mk(T_L, subs[i], adrs[i], 5'd10 + 5'(i), 32'h5A5A5A5A, 1, 32'h80FF7F01), 1'b0);
      n_checks++; if (rf_w_en !== 1'b1) begin n_fail++; $display("FAIL load_en[%0d] got=%0h exp=1", i, rf_w_en); end
      n_checks++; if (rf_w_data !== exps[i]) begin n_fail++; $display("FAIL load_data[%0d] got=%08h exp=%08h", i, rf_w_data, exps[i]); end
      n_checks++; if (bp_wb_val !== exps[i]) begin n_fail++; $display("FAIL load_bp_val[%0d] got=%08h exp=%08h", i, bp_wb_val, exps[i]); end
    end
    apply(mk(T_L, L_BAD, 0, 5'd12, 32'h1, 1, 32'h80FF7F01), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL load_unknown_en got=%0h exp=0", rf_w_en); end
    n_checks++; if (retired_cnt !== 32'd9) begin n_fail++; $display("FAIL load_retired got=%0d exp=9", retired_cnt); end
  endtask

  task automatic test_alu();
    apply(idle(), 1'b1);
    apply(mk(T_R, L_W, 0, 5'd0, 32'h1234, 0, 32'hFFFFFFFF), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL alu_x0_en got=%0h exp=0", rf_w_en); end
    n_checks++; if (bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL alu_x0_bp_reg got=%0h exp=0", bp_wb_reg); end
    n_checks++; if (retired_cnt !== 32'd1) begin n_fail++; $display("FAIL alu_x0_retired got=%0d exp=1", retired_cnt); end
    apply(mk(T_R, L_W, 0, 5'd7, 32'h1234, 0, 32'hFFFFFFFF), 1'b0);
    n_checks++; if (rf_w_en !== 1'b1) begin n_fail++; $display("FAIL alu_x7_en got=%0h exp=1", rf_w_en); end
    n_checks++; if (rf_w_addr !== 5'd7) begin n_fail++; $display("FAIL alu_x7_addr got=%0h exp=7", rf_w_addr); end
    n_checks++; if (rf_w_data !== 32'h1234) begin n_fail++; $display("FAIL alu_x7_data got=%0h exp=1234", rf_w_data); end
    n_checks++; if (bp_wb_reg !== 5'd7) begin n_fail++; $display("FAIL alu_x7_bp_reg got=%0h exp=7", bp_wb_reg); end
    n_checks++; if (bp_wb_val !== 32'h1234) begin n_fail++; $display("FAIL alu_x7_bp_val got=%0h exp=1234", bp_wb_val); end
    n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL alu_x7_retired got=%0d exp=2", retired_cnt); end
    apply(idle(), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0 || bp_wb_val !== 32'd0) begin n_fail++; $display("FAIL alu_bubble got=%0h/%0h exp=0/0", rf_w_en, bp_wb_val); end
    n_checks++; if (rf_w_data !== 32'h1234) begin n_fail++; $display("FAIL alu_bubble_hold got=%0h exp=1234", rf_w_data); end
  endtask

  task automatic test_stall();
    ins_t t;
    apply(idle(), 1'b1);
    apply(mk(T_I, L_W, 0, 5'd2, 32'h55, 0, 0), 1'b0);
    t = mk(T_R, L_W, 0, 5'd3, 32'h3333, 0, 0);
    t.stall = 1;
    for (int i = 0; i < 3; i++) begin
      apply(t, 1'b0);
      n_checks++; if (rf_w_en !== 1'b0) begin n_fail++; $display("FAIL stall_en[%0d] got=%0h exp=0", i, rf_w_en); end
      n_checks++; if (bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL stall_bp_reg[%0d] got=%0h exp=0", i, bp_wb_reg); end
      n_checks++; if (retired_cnt !== 32'd1) begin n_fail++; $display("FAIL stall_retired[%0d] got=%0d exp=1", i, retired_cnt); end
      n_checks++; if (rf_w_addr !== 5'd2 || rf_w_data !== 32'h55) begin n_fail++; $display("FAIL stall_hold[%0d] got=%0h/%0h exp=2/55", i, rf_w_addr, rf_w_data); end
    end
    t.stall = 0;
    apply(t, 1'b0);
    n_checks++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd3 || rf_w_data !== 32'h3333) begin n_fail++; $display("FAIL stall_release got=%0h/%0h/%0h exp=1/3/3333", rf_w_en, rf_w_addr, rf_w_data); end
    n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_release_retired got=%0d exp=2", retired_cnt); end
    apply(idle(), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0 || retired_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_after got=%0h/%0d exp=0/2", rf_w_en, retired_cnt); end
  endtask

  task automatic test_store_branch();
    apply(idle(), 1'b1);
    apply(mk(T_S, L_W, 0, 5'd9, 32'h99, 0, 0), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0 || bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL store_en got=%0h/%0h exp=0/0", rf_w_en, bp_wb_reg); end
    apply(mk(T_B, L_W, 0, 5'd9, 32'h99, 0, 0), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0 || bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL branch_en got=%0h/%0h exp=0/0", rf_w_en, bp_wb_reg); end
    n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL sb_retired got=%0d exp=2", retired_cnt); end
  endtask

  task automatic test_misaligned();
    apply(idle(), 1'b1);
    apply(mk(T_L, L_W, 2'd2, 5'd4, 0, 1, 32'hCAFEBABE), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0 || bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL mis_lw got=%0h/%0h exp=0/0", rf_w_en, bp_wb_reg); end
    apply(mk(T_L, L_H, 2'd3, 5'd4, 0, 1, 32'hCAFEBABE), 1'b0);
    n_checks++; if (rf_w_en !== 1'b0 || bp_wb_reg !== 5'd0) begin n_fail++; $display("FAIL mis_lh got=%0h/%0h exp=0/0", rf_w_en, bp_wb_reg); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%0h exp=1", misalign_err); end
    n_checks++; if (misalign_cnt !== 8'd2) begin n_fail++; $display("FAIL mis_cnt got=%0d exp=2", misalign_cnt); end
    n_checks++; if (retired_cnt !== 32'd2) begin n_fail++; $display("FAIL mis_retired got=%0d exp=2", retired_cnt); end
    apply(mk(T_L, L_B, 2'd3, 5'd4, 0, 1, 32'hCAFEBABE), 1'b0);
    n_checks++; if (rf_w_en !== 1'b1 || rf_w_data !== 32'hFFFFFFCA) begin n_fail++; $display("FAIL mis_lb_ok got=%0h/%0h exp=1/ffffffca", rf_w_en, rf_w_data); end
    n_checks++; if (misalign_err !== 1'b1 || misalign_cnt !== 8'd2) begin n_fail++; $display("FAIL mis_sticky got=%0h/%0d exp=1/2", misalign_err, misalign_cnt); end
    for (int i = 0; i < 300; i++) apply(mk(T_L, L_HU, 2'd1, 5'd8, 0, 1, 32'h0), 1'b0);
    n_checks++; if (misalign_cnt !== 8'd255) begin n_fail++; $display("FAIL mis_sat got=%0d exp=255", misalign_cnt); end
    n_checks++; if (retired_cnt !== 32'd303) begin n_fail++; $display("FAIL mis_sat_retired got=%0d exp=303", retired_cnt); end
  endtask

  task automatic test_back_to_back();
    ins_t t;
    logic [REG_AW+XLEN-1:0] got, exp;
    apply(idle(), 1'b1);
    exp_q.delete();
    for (int i = 0; i < 500; i++) begin
      t.valid   = ($urandom_range(0, 9) < 8);
      t.stall   = ($urandom_range(0, 3) == 0);
      t.typ     = 4'($urandom_range(0, 6));
      t.sub     = 4'($urandom_range(0, 5));
      t.addr    = 2'($urandom_range(0, 3));
      t.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      t.val     = $urandom;
      t.use_mem = (t.typ == T_L) ? 1'b1 : ($urandom_range(0, 7) == 0);
      t.ram     = $urandom;
      apply(t, 1'b0);
      n_checks++; if (rf_w_en !== m_en) begin n_fail++; $display("FAIL rnd_en[%0d] got=%0h exp=%0h", i, rf_w_en, m_en); end
      n_checks++; if (bp_wb_reg !== m_bp_reg || bp_wb_val !== m_bp_val) begin n_fail++; $display("FAIL rnd_bp[%0d] got=%0h/%08h exp=%0h/%08h", i, bp_wb_reg, bp_wb_val, m_bp_reg, m_bp_val); end
      n_checks++; if (retired_cnt !== m_ret) begin n_fail++; $display("FAIL rnd_retired[%0d] got=%0d exp=%0d", i, retired_cnt, m_ret); end
      n_checks++; if (misalign_err !== m_err || misalign_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_mis[%0d] got=%0h/%0d exp=%0h/%0d", i, misalign_err, misalign_cnt, m_err, m_cnt); end
      if (rf_w_en === 1'b1) begin
        got = {rf_w_addr, rf_w_data};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rnd_write[%0d] got=%0h/%08h exp=%0h/%08h", i, got[XLEN+:REG_AW], got[XLEN-1:0], exp[XLEN+:REG_AW], exp[XLEN-1:0]); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_missing_writes got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1; stall = 0; in_valid = 0; insn_type = 0; load_sub_type = 0;
    addr_lo = 0; wb_reg = 0; wb_val = 0; use_mem_output = 0; ram_r_data = 0;
    model_reset();
    test_reset();
    test_reset_mid();
    test_load_extract();
    test_alu();
    test_stall();
    test_store_branch();
    test_misaligned();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
